// File: rtl/alu_pipe.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-and-add multiplier that stalls the input while it runs.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] SRC1,
  input  logic [WIDTH-1:0] SRC2,
  input  logic [3:0]       ALU_CTRL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUTPUT,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             ILLEGAL
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_LSL   = 4'b0011,
    OP_LSR   = 4'b0100,
    OP_ASR   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_NOR   = 4'b1100
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e             state;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               carry;
  logic               overflow;
  logic               illegal;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   mul_sum;

  logic               accept;
  logic               is_mul;
  logic               mul_load;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH:0]     sar_w;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic               sc_ill;

  assign IN_READY = (state == S_IDLE) && (!out_valid || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign is_mul   = (ALU_CTRL == OP_MUL);

  // Final multiply step is folded into the load, so the product is ready on the count==0 edge.
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_load = (state == S_MUL) && (cnt == '0) && (!out_valid || OUT_READY);

  // Extra bit on each shift result captures the last bit shifted out (0 when amount is 0).
  assign shamt = SRC2[SHAMT_W-1:0];
  assign add_w = {1'b0, SRC1} + {1'b0, SRC2};
  assign sub_w = {1'b0, SRC1} - {1'b0, SRC2};
  assign shl_w = {1'b0, SRC1} << shamt;
  assign shr_w = {SRC1, 1'b0} >> shamt;
  assign sar_w = $signed({SRC1, 1'b0}) >>> shamt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (ALU_CTRL)
      OP_AND:   sc_res = SRC1 & SRC2;
      OP_OR:    sc_res = SRC1 | SRC2;
      OP_NOR:   sc_res = ~(SRC1 | SRC2);
      OP_PASSB: sc_res = SRC2;
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (SRC1[WIDTH-1] == SRC2[WIDTH-1]) && (add_w[WIDTH-1] != SRC1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = ~sub_w[WIDTH];
        sc_v   = (SRC1[WIDTH-1] != SRC2[WIDTH-1]) && (sub_w[WIDTH-1] != SRC1[WIDTH-1]);
      end
      OP_LSL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_LSR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      OP_ASR: begin
        sc_res = sar_w[WIDTH:1];
        sc_c   = sar_w[0];
      end
      OP_MUL:   sc_res = '0;
      default:  sc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept && !is_mul) begin
        result    <= sc_res;
        carry     <= sc_c;
        overflow  <= sc_v;
        illegal   <= sc_ill;
        out_valid <= 1'b1;
      end else if (mul_load) begin
        result    <= mul_sum;
        carry     <= 1'b0;
        overflow  <= 1'b0;
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end else if (out_valid && OUT_READY) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE:  if (accept && is_mul) state <= S_MUL;
        S_MUL:   if (mul_load) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: multiplier datapath is not reset; it is always loaded on accept before being read.
  always_ff @(posedge CLK) begin
    if (accept && is_mul) begin
      mcand  <= SRC1;
      mplier <= SRC2;
      acc    <= '0;
      cnt    <= SHAMT_W'(WIDTH - 1);
    end else if (state == S_MUL && cnt != '0) begin
      acc    <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  assign OUT_VALID  = out_valid;
  assign ALU_OUTPUT = result;
  assign Zero       = (result == '0);
  assign Negative   = result[WIDTH-1];
  assign Carry      = carry;
  assign Overflow   = overflow;
  assign ILLEGAL    = illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe against a wide-arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_output;
  logic        zero_f;
  logic        neg_f;
  logic        carry_f;
  logic        ovf_f;
  logic        illegal_f;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        ill;
  } exp_t;

  alu_pipe #(.WIDTH(64)) dut (
    .CLK        (clk),
    .RST        (rst),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .SRC1       (src1),
    .SRC2       (src2),
    .ALU_CTRL   (alu_ctrl),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .ALU_OUTPUT (alu_output),
    .Zero       (zero_f),
    .Negative   (neg_f),
    .Carry      (carry_f),
    .Overflow   (ovf_f),
    .ILLEGAL    (illegal_f)
  );

  always #5 clk = ~clk;

  // Reference model: 128-bit / 65-bit arithmetic straight from the opcode rules.
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t               e;
    logic [127:0]       w;
    logic signed [64:0] fr;
    int                 amt;
    e   = '0;
    amt = int'(b[5:0]);
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0111: e.res = b;
      4'b0010: begin
        w     = {64'b0, a} + {64'b0, b};
        e.res = w[63:0];
        e.c   = w[64];
        fr    = $signed({a[63], a}) + $signed({b[63], b});
        e.v   = fr[64] != fr[63];
      end
      4'b0110: begin
        e.res = a - b;
        e.c   = (a >= b);
        fr    = $signed({a[63], a}) - $signed({b[63], b});
        e.v   = fr[64] != fr[63];
      end
      4'b0011: begin
        w     = {64'b0, a} << amt;
        e.res = w[63:0];
        e.c   = w[64];
      end
      4'b0100: begin
        w     = {a, 64'b0} >> amt;
        e.res = w[127:64];
        e.c   = w[63];
      end
      4'b0101: begin
        w     = $signed({a, 64'b0}) >>> amt;
        e.res = w[127:64];
        e.c   = w[63];
      end
      4'b1000: begin
        w     = {64'b0, a} * {64'b0, b};
        e.res = w[63:0];
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 64'b0);
    e.n = e.res[63];
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_res"},   alu_output,     e.res);
    check({tag, "_z"},     64'(zero_f),    64'(e.z));
    check({tag, "_n"},     64'(neg_f),     64'(e.n));
    check({tag, "_c"},     64'(carry_f),   64'(e.c));
    check({tag, "_v"},     64'(ovf_f),     64'(e.v));
    check({tag, "_ill"},   64'(illegal_f), 64'(e.ill));
  endtask

  // Called just after a falling edge with OUT_READY=1; returns at the falling edge showing the result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, output exp_t e);
    int w;
    e        = model(op, a, b);
    in_valid = 1'b1;
    alu_ctrl = op;
    src1     = a;
    src2     = b;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_accept_wait"}, 64'(w < 200), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    alu_ctrl = 4'($urandom);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_latency"}, 64'(w), (op == 4'b1000) ? 64'd64 : 64'd0);
    check_out(tag, e);
  endtask

  initial begin
    exp_t        e;
    int          lat;
    int          busy;
    int          seen;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src1      = '0;
    src2      = '0;
    alu_ctrl  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_valid", 64'(out_valid),  64'd0);
    check("rst_res",   alu_output,      64'd0);
    check("rst_z",     64'(zero_f),     64'd1);
    check("rst_ncvi",  64'({neg_f, carry_f, ovf_f, illegal_f}), 64'd0);
    check("rst_ready", 64'(in_ready),   64'd1);

    run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, e);
    check("add_ovf_lit", alu_output, 64'h8000_0000_0000_0000);

    // Back-to-back SUBs at full throughput.
    in_valid = 1'b1; alu_ctrl = 4'b0110; src1 = 64'd5; src2 = 64'd5;
    @(posedge clk);
    #1;
    src1 = 64'd3;
    @(negedge clk);
    check_out("sub_eq", model(4'b0110, 64'd5, 64'd5));
    check("sub_eq_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_out("sub_lt", model(4'b0110, 64'd3, 64'd5));
    check("sub_lt_lit", alu_output, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("sub_drain", 64'(out_valid), 64'd0);

    // Backpressure: result held, second op stalls, both complete in order.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 4'b0000; src1 = 64'hF0; src2 = 64'h3C;
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0001; src1 = 64'h0F; src2 = 64'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_res",   alu_output,      64'h30);
      check("bp_hold_valid", 64'(out_valid),  64'd1);
      check("bp_hold_ready", 64'(in_ready),   64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_out("bp_second", model(4'b0001, 64'h0F, 64'h100));
    @(negedge clk);
    check("bp_drain", 64'(out_valid), 64'd0);

    run_op("lsl", 4'b0011, 64'h8000_0000_0000_0001, 64'h41, e);
    check("lsl_lit", alu_output, 64'h2);
    check("lsl_c",   64'(carry_f), 64'd1);
    run_op("asr", 4'b0101, 64'h8000_0000_0000_0000, 64'd63, e);
    check("asr_lit", alu_output, 64'hFFFF_FFFF_FFFF_FFFF);
    check("asr_c",   64'(carry_f), 64'd0);

    // Directed MUL: latency and busy window.
    in_valid = 1'b1; alu_ctrl = 4'b1000; src1 = 64'h1_0000_0003; src2 = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 0;
    busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy++;
      lat++;
      @(negedge clk);
    end
    check("mul_latency", 64'(lat),  64'd64);
    check("mul_busy",    64'(busy), 64'd64);
    check_out("mul", model(4'b1000, 64'h1_0000_0003, 64'd7));
    check("mul_lit", alu_output, 64'h7_0000_0015);
    @(negedge clk);

    // Reset in the middle of a MUL discards it.
    in_valid = 1'b1; alu_ctrl = 4'b1000; src1 = 64'h1234_5678; src2 = 64'h9ABC;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mulrst_valid", 64'(out_valid), 64'd0);
    check("mulrst_ready", 64'(in_ready),  64'd1);
    check("mulrst_res",   alu_output,     64'd0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mulrst_no_result", 64'(seen), 64'd0);

    run_op("illegal", 4'b1111, 64'hDEAD_BEEF, 64'h1234, e);
    check("illegal_flag", 64'(illegal_f), 64'd1);
    run_op("after_illegal", 4'b0010, 64'd10, 64'd20, e);
    check("after_illegal_flag", 64'(illegal_f), 64'd0);

    // Random opcodes/operands with occasional output backpressure.
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = {58'b0, 6'($urandom)} | {$urandom, 32'b0};
      if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_0000_0000;
      run_op("rand", op, a, b, e);
      lat = $urandom_range(0, 2);
      if (lat > 0) begin
        out_ready = 1'b0;
        repeat (lat) begin
          @(negedge clk);
          check("rand_hold_res",   alu_output,     e.res);
          check("rand_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
